// File: rtl/mul_io_sequencer_if.sv
// mul_io_sequencer_if: operand/result handshakes plus the xy multiplier register bus.
interface mul_io_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic [15:0] mul_D;
    logic        mul_W;
    logic        mul_R;
    logic        mul_E;
    logic [1:0]  mul_ADDR;
    logic [31:0] mul_OUT;

    modport master (
        input  in_valid, in_x, in_y, out_ready, mul_OUT,
        output in_ready, out_valid, out_product, mul_D, mul_W, mul_R, mul_E, mul_ADDR
    );

    modport slave (
        output in_valid, in_x, in_y, out_ready, mul_OUT,
        input  in_ready, out_valid, out_product, mul_D, mul_W, mul_R, mul_E, mul_ADDR
    );
endinterface

// File: rtl/mul_io_sequencer.sv
// mul_io_sequencer: drives the xy multiplier peripheral (write X, write Y, read product) for one operand pair.
// Optional MUL_OPERAND_CACHE_EN skips rewriting operands the peripheral already holds.
module mul_io_sequencer #(
    parameter logic [1:0] ADDR_X = 2'd0,
    parameter logic [1:0] ADDR_Y = 2'd1,
    parameter logic [1:0] ADDR_P = 2'd2
) (
    input logic              CLK,
    input logic              RST,
    mul_io_sequencer_if.master io
);
    typedef enum logic [2:0] {IDLE, WR_X, WR_Y, RD_P, CAPT, DONE} state_t;

    state_t      state_q, state_d;
    state_t      first_state, after_x;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [31:0] prod_q, prod_d;

`ifdef MUL_OPERAND_CACHE_EN
    logic [15:0] last_x_q, last_x_d, last_y_q, last_y_d;
    logic        cache_vld_q, cache_vld_d;

    // Valid only once both operands have been written since reset.
    always_comb begin
        last_x_d    = state_q == WR_X ? x_q : last_x_q;
        last_y_d    = state_q == WR_Y ? y_q : last_y_q;
        cache_vld_d = cache_vld_q | (state_q == WR_Y);
        first_state = !(cache_vld_q && io.in_x == last_x_q) ? WR_X :
                      !(cache_vld_q && io.in_y == last_y_q) ? WR_Y : RD_P;
        after_x     = (cache_vld_q && y_q == last_y_q) ? RD_P : WR_Y;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_x_q    <= '0;
            last_y_q    <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            last_x_q    <= last_x_d;
            last_y_q    <= last_y_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    always_comb begin
        first_state = WR_X;
        after_x     = WR_Y;
    end
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                x_d     = io.in_x;
                y_d     = io.in_y;
                state_d = first_state;
            end
            WR_X: state_d = after_x;
            WR_Y: state_d = RD_P;
            RD_P: state_d = CAPT;
            CAPT: begin
                prod_d  = io.mul_OUT;
                state_d = DONE;
            end
            DONE: if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            prod_q  <= prod_d;
        end
    end

    // Bus outputs are pure state decodes so no input reaches them combinationally.
    assign io.in_ready    = state_q == IDLE;
    assign io.out_valid   = state_q == DONE;
    assign io.out_product = prod_q;
    assign io.mul_W       = state_q == WR_X || state_q == WR_Y;
    assign io.mul_R       = state_q == RD_P;
    assign io.mul_E       = io.mul_W | io.mul_R;
    assign io.mul_ADDR    = state_q == WR_X ? ADDR_X :
                            state_q == WR_Y ? ADDR_Y :
                            state_q == RD_P ? ADDR_P : 2'd0;
    assign io.mul_D       = state_q == WR_X ? x_q :
                            state_q == WR_Y ? y_q : 16'd0;
endmodule

// File: tb/tb_mul_io_sequencer.sv
// tb_mul_io_sequencer: directed vectors against a behavioural xy multiplier peripheral.
module tb_mul_io_sequencer;
    logic CLK;
    logic RST;
    mul_io_sequencer_if io ();

    mul_io_sequencer dut (.CLK(CLK), .RST(RST), .io(io));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] xr = 16'd0;
    logic [15:0] yr = 16'd0;
    initial io.mul_OUT = 32'd0;

    always @(posedge CLK) begin
        if (io.mul_E && io.mul_W && io.mul_ADDR == 2'd0) xr <= io.mul_D;
        if (io.mul_E && io.mul_W && io.mul_ADDR == 2'd1) yr <= io.mul_D;
        if (io.mul_E && io.mul_R && io.mul_ADDR > 2'd1) io.mul_OUT <= {16'd0, xr} * {16'd0, yr};
    end

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] p;
        int          lat;
        logic        wx;
        logic        wy;
        int          hold;
    } vec_t;

    task automatic run(input vec_t v, input string tag);
        int lat, nw0, nw1, nr, both;
        logic [15:0] d0, d1;
        lat = 0; nw0 = 0; nw1 = 0; nr = 0; both = 0; d0 = 0; d1 = 0;
        @(negedge CLK);
        io.in_x = v.x;
        io.in_y = v.y;
        io.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        io.in_valid = 1'b0;
        io.in_x = 16'hDEAD;
        io.in_y = 16'hBEEF;
        while (!io.out_valid && lat < 20) begin
            if (io.mul_E && io.mul_W && io.mul_ADDR == 2'd0) begin nw0++; d0 = io.mul_D; end
            if (io.mul_E && io.mul_W && io.mul_ADDR == 2'd1) begin nw1++; d1 = io.mul_D; end
            if (io.mul_E && io.mul_R && io.mul_ADDR == 2'd2) nr++;
            if (io.mul_W && io.mul_R) both++;
            @(posedge CLK);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_product"}, io.out_product, v.p);
        chk({tag, "_nwrite_x"}, nw0, {31'd0, v.wx});
        chk({tag, "_nwrite_y"}, nw1, {31'd0, v.wy});
        if (v.wx) chk({tag, "_data_x"}, {16'd0, d0}, {16'd0, v.x});
        if (v.wy) chk({tag, "_data_y"}, {16'd0, d1}, {16'd0, v.y});
        chk({tag, "_nread_p"}, nr, 1);
        chk({tag, "_w_and_r"}, both, 0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge CLK);
            #1;
            chk({tag, "_hold_valid"}, {31'd0, io.out_valid}, 1);
            chk({tag, "_hold_product"}, io.out_product, v.p);
            chk({tag, "_hold_in_ready"}, {31'd0, io.in_ready}, 0);
        end
        @(negedge CLK);
        io.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        io.out_ready = 1'b0;
        chk({tag, "_idle_in_ready"}, {31'd0, io.in_ready}, 1);
        chk({tag, "_idle_out_valid"}, {31'd0, io.out_valid}, 0);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'd3, 16'd5, 32'd15, 4, 1'b1, 1'b1, 0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 4, 1'b1, 1'b1, 0};
        vecs[2] = '{16'd0, 16'd1234, 32'd0, 4, 1'b1, 1'b1, 0};
        vecs[3] = '{16'd3, 16'd5, 32'd15, 4, 1'b1, 1'b1, 5};
`ifdef MUL_OPERAND_CACHE_EN
        vecs[4] = '{16'd3, 16'd7, 32'd21, 3, 1'b0, 1'b1, 0};
        vecs[5] = '{16'd3, 16'd7, 32'd21, 2, 1'b0, 1'b0, 0};
`else
        vecs[4] = '{16'd3, 16'd7, 32'd21, 4, 1'b1, 1'b1, 0};
        vecs[5] = '{16'd3, 16'd7, 32'd21, 4, 1'b1, 1'b1, 0};
`endif
        RST = 1'b1;
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.in_x = 16'd0;
        io.in_y = 16'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'd0, io.out_valid}, 0);
        chk("rst_mul_w", {31'd0, io.mul_W}, 0);
        chk("rst_mul_r", {31'd0, io.mul_R}, 0);
        chk("rst_mul_e", {31'd0, io.mul_E}, 0);
        chk("rst_mul_addr", {30'd0, io.mul_ADDR}, 0);
        chk("rst_mul_d", {16'd0, io.mul_D}, 0);
        chk("rst_product", io.out_product, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("rel_in_ready", {31'd0, io.in_ready}, 1);
        chk("rel_out_valid", {31'd0, io.out_valid}, 0);

        for (int i = 0; i < 6; i++) run(vecs[i], $sformatf("vec%0d", i));

        @(negedge CLK);
        io.in_x = 16'd11;
        io.in_y = 16'd13;
        io.in_valid = 1'b1;
        @(posedge CLK);
        #1;
        io.in_valid = 1'b0;
        @(posedge CLK);
        #1;
        chk("wry_mul_w", {31'd0, io.mul_W}, 1);
        chk("wry_mul_addr", {30'd0, io.mul_ADDR}, 1);
        RST = 1'b1;
        #1;
        chk("mid_rst_mul_w", {31'd0, io.mul_W}, 0);
        chk("mid_rst_mul_r", {31'd0, io.mul_R}, 0);
        chk("mid_rst_mul_e", {31'd0, io.mul_E}, 0);
        chk("mid_rst_out_valid", {31'd0, io.out_valid}, 0);
        chk("mid_rst_in_ready", {31'd0, io.in_ready}, 1);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            chk("post_rst_no_valid", {31'd0, io.out_valid}, 0);
        end
        run('{16'd7, 16'd9, 32'd63, 4, 1'b1, 1'b1, 0}, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
